// File: rtl/store_buffer.sv
`default_nettype none
// store_buffer: in-order write-back store buffer with youngest-wins byte forwarding to loads.
// Rev 1.0 | optional feature macro STORE_BUF_COALESCE_EN (merge into youngest non-head entry).
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         st_valid_i,
  output logic                         st_ready_o,
  input  logic [ADDR_W-1:0]            st_addr_i,
  input  logic [DATA_W-1:0]            st_data_i,
  input  logic [DATA_W/8-1:0]          st_be_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  output logic                         ld_hit_o,
  output logic                         ld_partial_o,
  output logic [DATA_W-1:0]            ld_data_o,
  input  logic                         drain_req_i,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [ADDR_W-1:0]            mem_req_addr_o,
  output logic [DATA_W-1:0]            mem_req_data_o,
  output logic [DATA_W/8-1:0]          mem_req_be_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BE_W - 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];

  logic [PTR_W:0]    head_q, head_d, tail_q, tail_d, count;
  logic [PTR_W-1:0]  head_idx, tail_idx;
  logic              full, coal, push, pop;
  logic [ADDR_W-1:0] st_waddr, ld_waddr;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  // Extra wrap bit makes the pointer difference the exact occupancy (DEPTH is a power of two).
  assign count    = tail_q - head_q;
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign st_waddr = st_addr_i & ADDR_MASK;
  assign ld_waddr = ld_addr_i & ADDR_MASK;

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] young_idx;
  assign young_idx  = tail_idx - PTR_W'(1);
  // The head may be mid-handshake, so merging is only allowed into a non-head youngest entry.
  assign coal       = (count >= (PTR_W+1)'(2)) && (addr_q[young_idx] == st_waddr);
  assign st_ready_o = !drain_req_i && (!full || coal);
`else
  assign coal       = 1'b0;
  assign st_ready_o = !drain_req_i && !full;
`endif

  assign push   = st_valid_i && st_ready_o;
  assign pop    = mem_req_valid_o && mem_req_ready_i;
  assign head_d = head_q + (PTR_W+1)'(pop);
  assign tail_d = tail_q + (PTR_W+1)'(push && !coal);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push && !coal) begin
        addr_q[tail_idx] <= st_waddr;
        data_q[tail_idx] <= st_data_i;
        be_q[tail_idx]   <= st_be_i;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (push && coal) begin
        be_q[young_idx] <= be_q[young_idx] | st_be_i;
        for (int b = 0; b < BE_W; b++) begin
          if (st_be_i[b]) data_q[young_idx][8*b +: 8] <= st_data_i[8*b +: 8];
        end
      end
`endif
    end
  end

  assign mem_req_valid_o = (count != '0);
  assign empty_o         = (count == '0);
  assign count_o         = count;
  assign mem_req_addr_o  = addr_q[head_idx];
  assign mem_req_data_o  = data_q[head_idx];
  assign mem_req_be_o    = be_q[head_idx];

  logic [BE_W-1:0]   fwd_be;
  logic [DATA_W-1:0] fwd_data;

  // Walk entries oldest to youngest in logical order so later stores overwrite earlier bytes.
  always_comb begin
    fwd_be   = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_idx + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (addr_q[idx] == ld_waddr)) begin
        fwd_be = fwd_be | be_q[idx];
        for (int b = 0; b < BE_W; b++) begin
          if (be_q[idx][b]) fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
        end
      end
    end
  end

  assign ld_hit_o     = &fwd_be;
  assign ld_partial_o = (|fwd_be) && !(&fwd_be);
  assign ld_data_o    = ld_hit_o ? fwd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// tb_store_buffer: directed stimulus with a drain scoreboard checked by an independent monitor.
// Rev 1.0 | expectations follow STORE_BUF_COALESCE_EN when it is defined.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic [BE_W-1:0]   st_be = '0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              ld_hit, ld_partial;
  logic [DATA_W-1:0] ld_data;
  logic              drain_req = 1'b0;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_be;
  logic              empty;
  logic [CNT_W-1:0]  count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_be_i(st_be),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .ld_partial_o(ld_partial), .ld_data_o(ld_data),
    .drain_req_i(drain_req),
    .mem_req_valid_o(mem_valid), .mem_req_ready_i(mem_ready),
    .mem_req_addr_o(mem_addr), .mem_req_data_o(mem_data), .mem_req_be_o(mem_be),
    .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } req_t;

  req_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed handshake is popped against the scoreboard; stalled heads must hold.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic [BE_W-1:0]   prev_be;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall && mem_valid) begin
        chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
        chk("hold_data", 64'(mem_data), 64'(prev_data));
        chk("hold_be",   64'(mem_be),   64'(prev_be));
      end
      if (mem_valid && mem_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_drain", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          req_t e;
          e = expq.pop_front();
          chk("drain_addr", 64'(mem_addr), 64'(e.addr));
          chk("drain_data", 64'(mem_data), 64'(e.data));
          chk("drain_be",   64'(mem_be),   64'(e.be));
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
      prev_be    = mem_be;
    end
  end

  // One cycle of store presentation; acceptance is predicted by the bench, not read from the DUT.
  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [BE_W-1:0] be, input logic exp_acc, input logic rdy);
    req_t e;
    @(posedge clk); #1;
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be; mem_ready = rdy;
    @(negedge clk);
    chk("st_ready", 64'(st_ready), 64'(exp_acc));
    if (exp_acc) begin
      e.addr = a & ~ADDR_W'(BE_W - 1);
      e.data = d;
      e.be   = be;
      expq.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    @(posedge clk); #1;
    st_valid = 1'b0; st_be = '0; mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic chk_ld(input string name, input logic hit, input logic part,
                        input logic [DATA_W-1:0] d);
    chk({name, "_hit"},  64'(ld_hit),     64'(hit));
    chk({name, "_part"}, 64'(ld_partial), 64'(part));
    chk({name, "_data"}, 64'(ld_data),    64'(d));
  endtask

  task automatic drain_all();
    int budget;
    budget = 40;
    while (expq.size() != 0 && budget > 0) begin
      idle(1'b1);
      budget--;
    end
    chk("drain_done", 64'(expq.size()), 64'd0);
    idle(1'b0);
    chk("empty_after_drain", 64'(empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_valid",    64'(mem_valid), 64'd0);
    chk("rst_addr",     64'(mem_addr), 64'd0);
    chk("rst_data",     64'(mem_data), 64'd0);
    chk("rst_be",       64'(mem_be),   64'd0);
    chk_ld("rst_ld", 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill with memory stalled; head must stay presented and stable
    store(32'h100, 32'h1111_1111, 4'hF, 1'b1, 1'b0);
    store(32'h104, 32'h2222_2222, 4'hF, 1'b1, 1'b0);
    store(32'h108, 32'h3333_3333, 4'hF, 1'b1, 1'b0);
    store(32'h10C, 32'h4444_4444, 4'hF, 1'b1, 1'b0);
    idle(1'b0);
    chk("full_count",    64'(count),     64'd4);
    chk("full_st_ready", 64'(st_ready),  64'd0);
    chk("full_valid",    64'(mem_valid), 64'd1);
    chk("full_head",     64'(mem_addr),  64'h100);
    store(32'h110, 32'h9999_9999, 4'hF, 1'b0, 1'b0);

    // Same-word store into a full buffer whose youngest entry is 0x10C
`ifdef STORE_BUF_COALESCE_EN
    store(32'h10C, 32'h0000_FF00, 4'h2, 1'b1, 1'b0);
    expq.pop_back();
    expq.push_back('{addr: 32'h10C, data: 32'h4444_FF44, be: 4'hF});
    idle(1'b0);
    ld_addr = 32'h10C;
    idle(1'b0);
    chk("coal_count", 64'(count), 64'd4);
    chk_ld("coal_ld", 1'b1, 1'b0, 32'h4444_FF44);
`else
    store(32'h10C, 32'h0000_FF00, 4'h2, 1'b0, 1'b0);
    ld_addr = 32'h10C;
    idle(1'b0);
    chk("nocoal_count", 64'(count), 64'd4);
    chk_ld("nocoal_ld", 1'b1, 1'b0, 32'h4444_4444);
`endif

    // One pop, then simultaneous push and pop
    idle(1'b1);
    idle(1'b0);
    chk("pop_count",    64'(count),    64'd3);
    chk("pop_st_ready", 64'(st_ready), 64'd1);
    chk("pop_head",     64'(mem_addr), 64'h104);
    store(32'h110, 32'h5555_5555, 4'hF, 1'b1, 1'b1);
    idle(1'b0);
    chk("pushpop_count", 64'(count),    64'd3);
    chk("pushpop_head",  64'(mem_addr), 64'h108);

    // Asynchronous reset between edges while a drain request is pending
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("arst_valid",    64'(mem_valid), 64'd0);
    chk("arst_empty",    64'(empty),     64'd1);
    chk("arst_count",    64'(count),     64'd0);
    chk("arst_st_ready", 64'(st_ready),  64'd1);
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Youngest store wins per byte
    store(32'h200, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0);
    store(32'h200, 32'h0000_0011, 4'h1, 1'b1, 1'b0);
    ld_addr = 32'h200;
    idle(1'b0);
    chk_ld("merge_ld", 1'b1, 1'b0, 32'hAABB_CC11);
    ld_addr = 32'h201;
    idle(1'b0);
    chk_ld("merge_ld_offset", 1'b1, 1'b0, 32'hAABB_CC11);
    drain_all();

    // Partial coverage stalls the load and forwards nothing
    store(32'h300, 32'h0000_BEEF, 4'h3, 1'b1, 1'b0);
    ld_addr = 32'h302;
    idle(1'b0);
    chk_ld("partial_ld", 1'b0, 1'b1, 32'h0);
    ld_addr = 32'h304;
    idle(1'b0);
    chk_ld("miss_ld", 1'b0, 1'b0, 32'h0);
    drain_all();

    // Entries straddle the pointer wrap; age follows logical order
    store(32'h400, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
    store(32'h500, 32'h5566_7788, 4'hF, 1'b1, 1'b0);
    store(32'h400, 32'h0000_BB00, 4'h2, 1'b1, 1'b0);
    ld_addr = 32'h400;
    idle(1'b0);
    chk_ld("wrap_ld", 1'b1, 1'b0, 32'h1122_BB44);
    chk("wrap_count", 64'(count), 64'd3);

    // drain_req blocks stores while the drain carries on
    drain_req = 1'b1;
    store(32'h600, 32'h6666_6666, 4'hF, 1'b0, 1'b1);
    idle(1'b0);
    chk("drainreq_count", 64'(count), 64'd2);
    drain_all();
    drain_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
